// File: rtl/regfile_write_arbiter_pkg.sv
// Shared datapath types for the register-file write arbiter.
// The packed write request pairs a destination register with its data.
package regfile_write_arbiter_pkg;

   localparam int unsigned DEFAULT_ADDRESS_WIDTH = 5;
   localparam int unsigned DEFAULT_DATA_WIDTH    = 32;

   typedef struct packed {
      logic [DEFAULT_ADDRESS_WIDTH-1:0] rd;
      logic [DEFAULT_DATA_WIDTH-1:0]    wd;
   } wb_req_t;

   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Synchronous FIFO of write requests with a per-entry destination/valid view
// so the hazard unit can search every buffered result. DEPTH must be a power of two.
module wb_fifo
   import regfile_write_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH         = 2,
   parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter type         req_t         = wb_req_t
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 push_i,
   input  req_t                                 push_data_i,
   input  logic                                 pop_i,
   output req_t                                 head_o,
   output logic [$clog2(DEPTH):0]               count_o,
   output logic [DEPTH-1:0][ADDRESS_WIDTH-1:0]  entry_rd_o,
   output logic [DEPTH-1:0]                     entry_valid_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   req_t             mem_q [DEPTH];
   req_t             mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // A slot is live when its distance from the read pointer is below the count.
   always_comb begin
      entry_rd_o    = '0;
      entry_valid_o = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         entry_rd_o[i]    = mem_q[i].rd;
         entry_valid_o[i] = {1'b0, PTR_W'(PTR_W'(i) - rd_ptr_q)} < count_q;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: pipeline writeback first, buffered long-latency
// results second, with a starvation stall. Define WB_BYPASS_EN for the empty-FIFO bypass.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH    = 2,
   parameter int unsigned STARVE_LIMIT  = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     pipe_we_i,
   input  logic [ADDRESS_WIDTH-1:0] pipe_rd_i,
   input  logic [DATA_WIDTH-1:0]    pipe_wd_i,
   input  logic                     lu_valid_i,
   output logic                     lu_ready_o,
   input  logic [ADDRESS_WIDTH-1:0] lu_rd_i,
   input  logic [DATA_WIDTH-1:0]    lu_wd_i,
   output logic                     addr3_we_o,
   output logic [ADDRESS_WIDTH-1:0] addr3_o,
   output logic [DATA_WIDTH-1:0]    addr3_wd_o,
   output logic                     stall_o,
   input  logic [ADDRESS_WIDTH-1:0] query_rd_i,
   output logic                     query_hit_o
);

   localparam int unsigned CNT_W    = count_width(FIFO_DEPTH);
   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]    FULL_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0]    wd;
   } req_t;

   logic                                     pipe_fire;
   logic                                     lu_fire;
   logic                                     lu_keep;
   logic                                     fifo_empty;
   logic                                     fifo_push;
   logic                                     fifo_pop;
   logic                                     bypass;
   req_t                                     lu_req;
   req_t                                     fifo_head;
   logic [CNT_W-1:0]                         fifo_count;
   logic [FIFO_DEPTH-1:0][ADDRESS_WIDTH-1:0] entry_rd;
   logic [FIFO_DEPTH-1:0]                    entry_valid;

   logic                     we_q, we_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    wd_q, wd_d;
   logic [STARVE_W-1:0]      starve_q, starve_d;

   wb_fifo #(
      .DEPTH         (FIFO_DEPTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .req_t         (req_t)
   ) u_wb_fifo (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .push_i        (fifo_push),
      .push_data_i   (lu_req),
      .pop_i         (fifo_pop),
      .head_o        (fifo_head),
      .count_o       (fifo_count),
      .entry_rd_o    (entry_rd),
      .entry_valid_o (entry_valid)
   );

   // Writes to x0 are architecturally void, so they neither win arbitration nor enter the FIFO.
   always_comb begin
      lu_req.rd  = lu_rd_i;
      lu_req.wd  = lu_wd_i;
      lu_ready_o = (fifo_count != FULL_COUNT);
      pipe_fire  = pipe_we_i && (pipe_rd_i != '0);
      lu_fire    = lu_valid_i && lu_ready_o;
      lu_keep    = lu_fire && (lu_rd_i != '0);
      fifo_empty = (fifo_count == '0);
`ifdef WB_BYPASS_EN
      bypass     = fifo_empty && !pipe_fire && lu_keep;
`else
      bypass     = 1'b0;
`endif
      fifo_pop   = !pipe_fire && !fifo_empty;
      fifo_push  = lu_keep && !bypass;
   end

   always_comb begin
      we_d   = 1'b0;
      addr_d = addr_q;
      wd_d   = wd_q;
      if (pipe_fire) begin
         we_d   = 1'b1;
         addr_d = pipe_rd_i;
         wd_d   = pipe_wd_i;
      end else if (fifo_pop) begin
         we_d   = 1'b1;
         addr_d = fifo_head.rd;
         wd_d   = fifo_head.wd;
      end else if (bypass) begin
         we_d   = 1'b1;
         addr_d = lu_rd_i;
         wd_d   = lu_wd_i;
      end
   end

   // Counts pipeline wins over a waiting head; saturates so stall holds if ignored.
   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || fifo_pop) begin
         starve_d = '0;
      end else if (pipe_fire && (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_q     <= 1'b0;
         addr_q   <= '0;
         wd_q     <= '0;
         starve_q <= '0;
      end else begin
         we_q     <= we_d;
         addr_q   <= addr_d;
         wd_q     <= wd_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      query_hit_o = 1'b0;
      if (query_rd_i != '0) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (entry_valid[i] && (entry_rd[i] == query_rd_i)) begin
               query_hit_o = 1'b1;
            end
         end
      end
   end

   assign addr3_we_o = we_q;
   assign addr3_o    = addr_q;
   assign addr3_wd_o = wd_q;
   assign stall_o    = (starve_q == STARVE_MAX);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a cycle model queues the expected
// write-port traffic, and a negedge monitor compares it against the DUT.
module tb_regfile_write_arbiter;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] wd;
   } item_t;

   logic        clk;
   logic        rst_n;
   logic        pipe_we;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_wd;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_rd;
   logic [31:0] lu_wd;
   logic        addr3_we;
   logic [4:0]  addr3;
   logic [31:0] addr3_wd;
   logic        stall;
   logic [4:0]  query_rd;
   logic        query_hit;

   int    checkCount = 0;
   int    passCount  = 0;
   item_t mq[$];
   item_t expq[$];
   int    mStarve = 0;

   regfile_write_arbiter #(
      .ADDRESS_WIDTH (5),
      .DATA_WIDTH    (32),
      .FIFO_DEPTH    (DEPTH),
      .STARVE_LIMIT  (LIMIT)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .pipe_we_i   (pipe_we),
      .pipe_rd_i   (pipe_rd),
      .pipe_wd_i   (pipe_wd),
      .lu_valid_i  (lu_valid),
      .lu_ready_o  (lu_ready),
      .lu_rd_i     (lu_rd),
      .lu_wd_i     (lu_wd),
      .addr3_we_o  (addr3_we),
      .addr3_o     (addr3),
      .addr3_wd_o  (addr3_wd),
      .stall_o     (stall),
      .query_rd_i  (query_rd),
      .query_hit_o (query_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end else begin
         passCount++;
      end
   endtask

   function automatic bit modelHit();
      if (query_rd == 5'd0) return 1'b0;
      foreach (mq[i]) begin
         if (mq[i].rd == query_rd) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void modelStep();
      bit    pf, lk, byp, empty0;
      item_t li;
      pf     = pipe_we && (pipe_rd != 5'd0);
      empty0 = (mq.size() == 0);
      lk     = lu_valid && (mq.size() != DEPTH) && (lu_rd != 5'd0);
      byp    = 1'b0;
`ifdef WB_BYPASS_EN
      byp    = empty0 && !pf && lk;
`endif
      li = '{rd: lu_rd, wd: lu_wd};
      if (pf) begin
         expq.push_back('{rd: pipe_rd, wd: pipe_wd});
         if (!empty0 && mStarve < LIMIT) mStarve++;
      end else if (!empty0) begin
         expq.push_back(mq.pop_front());
      end else if (byp) begin
         expq.push_back(li);
      end
      if (!pf || empty0) mStarve = 0;
      if (lk && !byp) mq.push_back(li);
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
            expq.delete();
            mStarve = 0;
         end else begin
            modelStep();
         end
      end
   end

   initial begin
      item_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (expq.size() > 0) begin
               e = expq.pop_front();
               checkOutput("sb_we", 64'(addr3_we), 64'(1'b1));
               checkOutput("sb_addr", 64'(addr3), 64'(e.rd));
               checkOutput("sb_wd", 64'(addr3_wd), 64'(e.wd));
            end else begin
               checkOutput("sb_idle_we", 64'(addr3_we), 64'(1'b0));
            end
            checkOutput("sb_stall", 64'(stall), 64'(mStarve == LIMIT));
            checkOutput("sb_ready", 64'(lu_ready), 64'(mq.size() != DEPTH));
            checkOutput("sb_query", 64'(query_hit), 64'(modelHit()));
         end
      end
   end

   task automatic applyStimulus(input bit pwe, input logic [4:0] prd, input logic [31:0] pwd,
                                input bit lv, input logic [4:0] lrd, input logic [31:0] lwd,
                                output bit fired);
      pipe_we  = pwe;
      pipe_rd  = prd;
      pipe_wd  = pwd;
      lu_valid = lv;
      lu_rd    = lrd;
      lu_wd    = lwd;
      fired    = lv && lu_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      bit f;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, f);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit          f;
      bit          luPending;
      logic [4:0]  luRdR;
      logic [31:0] luWdR;
      bit          pwe;

      rst_n = 1'b0;
      pipe_we = 1'b0; pipe_rd = '0; pipe_wd = '0;
      lu_valid = 1'b0; lu_rd = '0; lu_wd = '0;
      query_rd = '0;
      repeat (3) @(posedge clk);
      #1;
      $display("[TB] reset values");
      checkOutput("rst_we", 64'(addr3_we), 64'(0));
      checkOutput("rst_addr", 64'(addr3), 64'(0));
      checkOutput("rst_wd", 64'(addr3_wd), 64'(0));
      checkOutput("rst_stall", 64'(stall), 64'(0));
      checkOutput("rst_ready", 64'(lu_ready), 64'(1));
      checkOutput("rst_hit", 64'(query_hit), 64'(0));
      rst_n = 1'b1;
      idleCycles(2);

      $display("[TB] lone long-latency result");
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, f);
      checkOutput("lone_fire", 64'(f), 64'(1));
`ifdef WB_BYPASS_EN
      checkOutput("lone_n1_we", 64'(addr3_we), 64'(1));
      checkOutput("lone_n1_addr", 64'(addr3), 64'(5));
      checkOutput("lone_n1_wd", 64'(addr3_wd), 64'hDEADBEEF);
`else
      checkOutput("lone_n1_we", 64'(addr3_we), 64'(0));
      idleCycles(1);
      checkOutput("lone_n2_we", 64'(addr3_we), 64'(1));
      checkOutput("lone_n2_addr", 64'(addr3), 64'(5));
      checkOutput("lone_n2_wd", 64'(addr3_wd), 64'hDEADBEEF);
`endif
      idleCycles(2);

      $display("[TB] starvation stall");
      applyStimulus(1'b1, 5'd7, 32'h7000_0000, 1'b1, 5'd9, 32'h9999_0009, f);
      checkOutput("starve_push", 64'(f), 64'(1));
      checkOutput("starve_stall0", 64'(stall), 64'(0));
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b1, 5'd7, 32'h7000_0000 + 32'(k), 1'b0, 5'd0, 32'd0, f);
         checkOutput("starve_pipe_addr", 64'(addr3), 64'(7));
         checkOutput("starve_stall", 64'(stall), 64'(k == 4));
      end
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, f);
      checkOutput("starve_issue_we", 64'(addr3_we), 64'(1));
      checkOutput("starve_issue_addr", 64'(addr3), 64'(9));
      checkOutput("starve_stall_fall", 64'(stall), 64'(0));
      idleCycles(1);

      $display("[TB] fill and query");
      applyStimulus(1'b1, 5'd7, 32'h7, 1'b1, 5'd3, 32'h3333, f);
      applyStimulus(1'b1, 5'd7, 32'h8, 1'b1, 5'd4, 32'h4444, f);
      checkOutput("full_ready", 64'(lu_ready), 64'(0));
      query_rd = 5'd4; #1;
      checkOutput("query_hit4", 64'(query_hit), 64'(1));
      query_rd = 5'd0; #1;
      checkOutput("query_x0", 64'(query_hit), 64'(0));
      query_rd = 5'd9; #1;
      checkOutput("query_miss", 64'(query_hit), 64'(0));
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, f);
      checkOutput("drain_first", 64'(addr3), 64'(3));
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, f);
      checkOutput("drain_second", 64'(addr3), 64'(4));
      checkOutput("drain_second_wd", 64'(addr3_wd), 64'h4444);
      query_rd = 5'd0;
      idleCycles(1);

      $display("[TB] x0 writes");
      applyStimulus(1'b1, 5'd0, 32'hBAD0, 1'b1, 5'd0, 32'hBAD1, f);
      checkOutput("x0_fire", 64'(f), 64'(1));
      checkOutput("x0_we", 64'(addr3_we), 64'(0));
      checkOutput("x0_ready", 64'(lu_ready), 64'(1));
      idleCycles(1);
      checkOutput("x0_we_after", 64'(addr3_we), 64'(0));

      $display("[TB] full with pop and valid");
      applyStimulus(1'b1, 5'd7, 32'h70, 1'b1, 5'd10, 32'hA0A0, f);
      applyStimulus(1'b1, 5'd7, 32'h71, 1'b1, 5'd11, 32'hB1B1, f);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC2C2, f);
      checkOutput("fullpop_nofire", 64'(f), 64'(0));
      checkOutput("fullpop_addr", 64'(addr3), 64'(10));
      checkOutput("fullpop_ready_rise", 64'(lu_ready), 64'(1));
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC2C2, f);
      checkOutput("fullpop_fire", 64'(f), 64'(1));
      checkOutput("fullpop_second", 64'(addr3), 64'(11));
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, f);
      checkOutput("fullpop_third", 64'(addr3), 64'(12));
      checkOutput("fullpop_third_wd", 64'(addr3_wd), 64'hC2C2);
      idleCycles(1);

      $display("[TB] mid-stream reset");
      applyStimulus(1'b1, 5'd7, 32'h72, 1'b1, 5'd13, 32'hD3D3, f);
      applyStimulus(1'b1, 5'd7, 32'h73, 1'b1, 5'd14, 32'hE4E4, f);
      pipe_we = 1'b0; lu_valid = 1'b0;
      query_rd = 5'd13;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_we", 64'(addr3_we), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checkOutput("midrst_stall", 64'(stall), 64'(0));
      checkOutput("midrst_ready", 64'(lu_ready), 64'(1));
      checkOutput("midrst_hit", 64'(query_hit), 64'(0));
      idleCycles(3);
      checkOutput("midrst_idle_we", 64'(addr3_we), 64'(0));
      query_rd = 5'd0;

      $display("[TB] random traffic");
      luPending = 1'b0;
      luRdR = '0;
      luWdR = '0;
      for (int c = 0; c < 400; c++) begin
         pwe = !stall && ($urandom_range(0, 99) < 60);
         if (!luPending && ($urandom_range(0, 99) < 45)) begin
            luPending = 1'b1;
            luRdR = 5'($urandom_range(0, 15));
            luWdR = $urandom;
         end
         query_rd = 5'($urandom_range(0, 15));
         applyStimulus(pwe, 5'($urandom_range(0, 15)), $urandom, luPending, luRdR, luWdR, f);
         if (f) luPending = 1'b0;
      end
      query_rd = 5'd0;
      idleCycles(8);
      checkOutput("sb_drain", 64'(expq.size()), 64'(0));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Write-port arbiter that owns the register file's single write port (addr3_we/addr3/wd). Merges in-order pipeline writeback with results from a long-latency unit (divider or load unit) over a valid/ready handshake. Long-latency results are buffered in a small FIFO. A bounded-starvation counter stalls the pipeline so buffered results always retire. Sits between the writeback stage and the register file, and exports a pending-destination query for the hazard unit.

## Interface
- ADDRESS_WIDTH, 5, register index width
- DATA_WIDTH, 32, register data width
- FIFO_DEPTH, 2, long-latency result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive lost arbitrations before stall_o asserts (≥1)

Ports:
- clk_i  in  1  clock; all state updates on posedge
- rst_ni  in  1  asynchronous, active-low reset
- pipe_we_i  in  1  pipeline writeback valid (never back-pressured)
- pipe_rd_i  in  ADDRESS_WIDTH  pipeline destination register
- pipe_wd_i  in  DATA_WIDTH  pipeline write data
- lu_valid_i  in  1  long-latency result valid
- lu_ready_o  out  1  FIFO can accept a result
- lu_rd_i  in  ADDRESS_WIDTH  long-latency destination register
- lu_wd_i  in  DATA_WIDTH  long-latency write data
- addr3_we_o  out  1  register file write enable (registered)
- addr3_o  out  ADDRESS_WIDTH  register file write address (registered)
- addr3_wd_o  out  DATA_WIDTH  register file write data (registered)
- stall_o  out  1  pipeline must hold writeback; FIFO draining
- query_rd_i  in  ADDRESS_WIDTH  hazard-unit register lookup
- query_hit_o  out  1  query_rd_i matches a valid FIFO entry (combinational)

## Operation
- lu handshake fires when lu_valid_i && lu_ready_o. lu_ready_o = (count != FIFO_DEPTH), a function of registered count only; no push when full, even if popping that cycle.
- A fired lu result with lu_rd_i == 0 is dropped (handshake completes, nothing enqueued). Pipeline writes with pipe_rd_i == 0 are treated as pipe_we_i = 0.
- Per-cycle issue priority into the output register:
  1. pipeline write
  2. FIFO head (pop)
  3. bypass (see Configuration)
  4. idle: addr3_we_o = 0; address and data hold their previous values.
- Push and pop in the same cycle are both allowed; count is unchanged.
- starve_cnt: increments (saturating at STARVE_LIMIT) each cycle the FIFO is non-empty and the pipeline wins. Clears to 0 whenever the head is popped or the FIFO is empty.
- stall_o = (starve_cnt == STARVE_LIMIT), decoded from the register.
- The upstream pipeline must drive pipe_we_i = 0 while stall_o is high. If it does not, the pipeline still wins and the counter stays saturated.
- The block does not resolve WAW between buffered and pipeline writes. The hazard unit must stall on query_hit_o. query_hit_o is 0 when query_rd_i == 0.
- Reset: FIFO flushed and count = 0; starve_cnt = 0; addr3_we_o = 0, addr3_o = 0, addr3_wd_o = 0; stall_o = 0; lu_ready_o = 1 after reset. A result mid-handshake at reset is lost.

## Timing
- Pipeline write: accepted in cycle N, addr3_* valid in cycle N+1. The register file captures it on the negedge of cycle N+1.
- Long-latency result, no bypass: push in N, earliest pop in N+1, addr3_* in N+2.
- Long-latency result with bypass: addr3_* in N+1.
- Worst-case buffered latency: STARVE_LIMIT cycles, plus 1 stall cycle, plus FIFO position.
- Simultaneous events:
  - Pipeline write + FIFO non-empty + lu push: pipeline issued, lu pushed, starve_cnt increments.
  - FIFO full + pop + lu_valid_i: lu_ready_o = 0 that cycle; it rises the next cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.

## Configuration
- WB_BYPASS_EN defined: when the FIFO is empty, pipe_we_i is 0, and an lu result fires with nonzero rd, the result goes straight to the output register and is not enqueued (1-cycle latency).
- WB_BYPASS_EN undefined: every lu result goes through the FIFO (2-cycle minimum latency).
- Interface is identical either way.

## Structure
- Shared package (datapath pkg): typedef wb_req_t {rd, wd}, plus the ADDRESS_WIDTH and DATA_WIDTH defaults.
- One sub-module: wb_fifo, a parametric synchronous FIFO of wb_req_t. It exposes count plus a per-entry rd/valid vector for the query match.
- Arbitration, starve counter and output register live in the top.

## Test plan
- Reset: assert rst_ni = 0 mid-stream with 2 entries buffered -> addr3_we_o = 0, stall_o = 0, lu_ready_o = 1, query_hit_o = 0 after release.
- Lone lu result rd = 5, wd = 0xDEADBEEF, idle pipeline -> addr3_we_o = 1, addr3_o = 5 at N+2 (N+1 with WB_BYPASS_EN).
- Pipeline writes x7 every cycle while lu pushes x9 -> x9 held; stall_o rises after 4 pipeline wins; x9 issued on the first stalled cycle; stall_o falls the next cycle.
- Fill FIFO (x3, x4) with pipeline busy -> lu_ready_o = 0. query_rd_i = 4 gives query_hit_o = 1; query_rd_i = 0 gives 0. Drain order is x3 then x4.
- lu rd = 0 and pipe rd = 0 writes -> no addr3_we_o pulse; count unchanged.
- Full FIFO with a pop and lu_valid_i in the same cycle -> no push that cycle; the push is accepted the next cycle and order is preserved.
